fifo_burst_reader: RTL and testbench

- Read-side controller for fifo_single_clock_reg_v2. It drains the FIFO in bursts and presents the words downstream on a valid/ready stream with an end-of-burst marker.
- Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so downstream backpressure never loses data.
- Sits between the FIFO read port and any consumer.

---
 rtl/fifo_burst_reader.sv | 101 ++++++++++
 tb/tb_fifo_burst_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a registered-read FIFO in bursts onto a valid/ready stream via a 2-entry skid.
// Optional FIFO_BURST_READER_STATS_EN adds stat_words/stat_bursts counters.
module fifo_burst_reader #(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 4,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              f_r_req,
   input  logic [DATA_W-1:0] f_r_data,
   input  logic [CNT_W-1:0]  f_cnt,
   input  logic              f_empty,
   input  logic              f_fail,
   input  logic              flush,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              err
`ifdef FIFO_BURST_READER_STATS_EN
   ,
   output logic [15:0]       stat_words,
   output logic [15:0]       stat_bursts
`endif
);
   typedef enum logic [1:0] {IDLE, BURST, WAIT_OUT} state_t;
   state_t state, state_n;
   logic [3:0] issued, blen;
   logic [1:0] occ;
   logic [DATA_W-1:0] d0, d1;
   logic l0, l1, inflight, inflight_last;
   logic pop, push, credit_ok, issue_last, wr1, thresh;
   assign m_valid    = occ != 2'd0;
   assign m_data     = d0;
   assign m_last     = m_valid & l0;
   assign pop        = m_valid & m_ready;
   assign push       = inflight & ~f_fail;
   // credit = 2 - occ - inflight + pop >= 1, rearranged to stay unsigned
   assign credit_ok  = ({1'b0, occ} + {2'b0, inflight}) <= ({2'b0, pop} + 3'd1);
   assign f_r_req    = (state == BURST) && (issued < blen) && credit_ok && !f_empty;
   assign issue_last = issued == blen - 4'd1;
   assign busy       = state != IDLE;
   assign thresh     = f_cnt >= CNT_W'(BURST_LEN);
   assign wr1        = (occ == 2'd2) || (occ == 2'd1 && !pop);
   always_comb begin
      state_n = state;
      if (state == IDLE && (thresh || (flush && f_cnt != '0))) state_n = BURST;
      if (state == BURST && f_r_req && issue_last) state_n = WAIT_OUT;
      if (state == WAIT_OUT && occ == 2'd0 && !inflight) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         issued        <= '0;
         blen          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         err           <= 1'b0;
         occ           <= '0;
         d0            <= '0;
         d1            <= '0;
         l0            <= 1'b0;
         l1            <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == BURST) begin
            blen   <= thresh ? 4'(BURST_LEN) : 4'(f_cnt);
            issued <= '0;
         end else if (f_r_req) issued <= issued + 4'd1;
         inflight      <= f_r_req;
         inflight_last <= f_r_req & issue_last;
         err           <= err | (inflight & f_fail);
         occ           <= occ + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            d0 <= d1;
            l0 <= l1;
         end
         // a write to slot 0 overrides the shift when the head pops with one entry left
         if (push && wr1) begin
            d1 <= f_r_data;
            l1 <= inflight_last;
         end else if (push) begin
            d0 <= f_r_data;
            l0 <= inflight_last;
         end
      end
   end
`ifdef FIFO_BURST_READER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_words  <= '0;
         stat_bursts <= '0;
      end else begin
         if (pop) stat_words <= stat_words + 16'd1;
         if (pop && m_last) stat_bursts <= stat_bursts + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed tests for fifo_burst_reader against a small registered-read FIFO model.
module tb_fifo_burst_reader;
   logic        clk = 1'b0, rst = 1'b1;
   logic        f_r_req, f_empty, flush = 1'b0, m_valid, m_last, m_ready = 1'b1, busy, err;
   logic        f_fail = 1'b0, fifo_clr = 1'b0;
   logic [31:0] f_r_data = '0, m_data;
   logic [3:0]  f_cnt;
`ifdef FIFO_BURST_READER_STATS_EN
   logic [15:0] stat_words, stat_bursts;
`endif
   logic [31:0] mem [64];
   int          wp = 0, rp = 0, rdn = 0, fail_idx = -1, nacc = 0;
   logic [31:0] got_d [256];
   logic        got_l [256];
   int          compared = 0, mismatched = 0;

   fifo_burst_reader dut (
      .clk(clk), .rst(rst), .f_r_req(f_r_req), .f_r_data(f_r_data), .f_cnt(f_cnt),
      .f_empty(f_empty), .f_fail(f_fail), .flush(flush), .m_valid(m_valid), .m_data(m_data),
      .m_last(m_last), .m_ready(m_ready), .busy(busy), .err(err)
`ifdef FIFO_BURST_READER_STATS_EN
      , .stat_words(stat_words), .stat_bursts(stat_bursts)
`endif
   );

   always #5 clk = ~clk;

   assign f_cnt   = 4'(wp - rp);
   assign f_empty = wp == rp;

   // FIFO model: data appears the cycle after the request; f_fail can target one read index
   always @(posedge clk) begin
      f_fail <= f_r_req && (rdn == fail_idx);
      if (f_r_req) rdn <= rdn + 1;
      if (fifo_clr) rp <= wp;
      else if (f_r_req) begin
         f_r_data <= mem[rp];
         rp       <= rp + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         got_d[nacc] = m_data;
         got_l[nacc] = m_last;
         nacc = nacc + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) mem[wp + i] = base + 32'(i);
      wp = wp + n;
   endtask

   task automatic wait_acc(input int target, input int budget);
      for (int i = 0; i < budget && nacc < target; i++) step();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) step();
   endtask

   task automatic test_reset();
      #12;
      compared++;
      if ({f_r_req, m_valid, m_last, busy, err} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b need 00000", {f_r_req, m_valid, m_last, busy, err});
      end
      compared++;
      if (m_data !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_data: got %h need 0", m_data);
      end
   endtask

   task automatic test_threshold();
      int r = 0, b = 0;
      step();
      rst = 1'b0;
      load(32'hA000_0000, 3);
      repeat (20) begin
         @(negedge clk);
         r += int'(f_r_req);
         b += int'(busy);
      end
      compared++;
      if (r !== 0) begin
         mismatched++;
         $display("FAIL thresh_req: got %0d req cycles need 0", r);
      end
      compared++;
      if (b !== 0) begin
         mismatched++;
         $display("FAIL thresh_busy: got %0d busy cycles need 0", b);
      end
      step();
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
   endtask

   task automatic test_full_rate();
      logic [15:0] rq, vv, ll;
      logic [31:0] dd [16];
      int base;
      int k = 0;
      step();
      base = nacc;
      load(32'h1000_0000, 10);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rq[i] = f_r_req;
         vv[i] = m_valid;
         ll[i] = m_last;
         dd[i] = m_data;
      end
      compared++;
      if (rq !== 16'h1E1E) begin
         mismatched++;
         $display("FAIL full_req_pattern: got %h need 1e1e", rq);
      end
      compared++;
      if (vv !== 16'h7878) begin
         mismatched++;
         $display("FAIL full_valid_pattern: got %h need 7878", vv);
      end
      compared++;
      if (ll !== 16'h4040) begin
         mismatched++;
         $display("FAIL full_last_pattern: got %h need 4040", ll);
      end
      for (int i = 0; i < 16; i++) begin
         if ((16'h7878 >> i) & 16'h1) begin
            compared++;
            if (dd[i] !== 32'h1000_0000 + 32'(k)) begin
               mismatched++;
               $display("FAIL full_data[%0d]: got %h need %h", i, dd[i], 32'h1000_0000 + 32'(k));
            end
            k++;
         end
      end
      wait_idle(30);
      compared++;
      if (busy !== 1'b0 || nacc !== base + 8) begin
         mismatched++;
         $display("FAIL full_done: got busy=%b words=%0d need busy=0 words=8", busy, nacc - base);
      end
   endtask

   task automatic test_flush();
      int base = nacc;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_acc(base + 2, 20);
      wait_idle(20);
      compared++;
      if (nacc !== base + 2) begin
         mismatched++;
         $display("FAIL flush_count: got %0d need 2", nacc - base);
      end
      for (int i = 0; i < 2; i++) begin
         compared++;
         if (got_d[base + i] !== 32'h1000_0008 + 32'(i) || got_l[base + i] !== (i == 1)) begin
            mismatched++;
            $display("FAIL flush_word[%0d]: got %h/%b need %h/%b", i, got_d[base + i], got_l[base + i],
                     32'h1000_0008 + 32'(i), i == 1);
         end
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_idle: got busy=%b need 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int base = nacc, r0 = rdn;
      m_ready = 1'b0;
      load(32'hB000_0000, 4);
      repeat (10) @(negedge clk);
      compared++;
      if (rdn - r0 !== 2) begin
         mismatched++;
         $display("FAIL bp_reads_stalled: got %0d need 2", rdn - r0);
      end
      compared++;
      if (m_valid !== 1'b1 || m_data !== 32'hB000_0000) begin
         mismatched++;
         $display("FAIL bp_hold: got valid=%b data=%h need 1/b0000000", m_valid, m_data);
      end
      step();
      m_ready = 1'b1;
      wait_acc(base + 4, 30);
      wait_idle(20);
      compared++;
      if (rdn - r0 !== 4 || nacc !== base + 4) begin
         mismatched++;
         $display("FAIL bp_totals: got reads=%0d words=%0d need 4/4", rdn - r0, nacc - base);
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (got_d[base + i] !== 32'hB000_0000 + 32'(i) || got_l[base + i] !== (i == 3)) begin
            mismatched++;
            $display("FAIL bp_word[%0d]: got %h/%b need %h/%b", i, got_d[base + i], got_l[base + i],
                     32'hB000_0000 + 32'(i), i == 3);
         end
      end
   endtask

   task automatic test_fail();
      int base = nacc;
      logic [31:0] ed [3];
      logic        el [3];
      ed = '{32'hC000_0000, 32'hC000_0002, 32'hC000_0003};
      el = '{1'b0, 1'b0, 1'b1};
      fail_idx = rdn + 1;
      load(32'hC000_0000, 4);
      wait_acc(base + 3, 30);
      wait_idle(20);
      fail_idx = -1;
      compared++;
      if (nacc !== base + 3) begin
         mismatched++;
         $display("FAIL fail_count: got %0d need 3", nacc - base);
      end
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (got_d[base + i] !== ed[i] || got_l[base + i] !== el[i]) begin
            mismatched++;
            $display("FAIL fail_word[%0d]: got %h/%b need %h/%b", i, got_d[base + i], got_l[base + i], ed[i], el[i]);
         end
      end
      repeat (5) step();
      compared++;
      if (err !== 1'b1) begin
         mismatched++;
         $display("FAIL fail_err_sticky: got %b need 1", err);
      end
   endtask

   task automatic test_reset_mid();
      int base = nacc;
      load(32'hD000_0000, 8);
      for (int i = 0; i < 30 && nacc < base + 2; i++) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      compared++;
      if ({m_valid, f_r_req, busy, err} !== 4'b0) begin
         mismatched++;
         $display("FAIL rstmid_outputs: got %b need 0000 (accepted %0d)", {m_valid, f_r_req, busy, err}, nacc - base);
      end
      step();
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
      rst = 1'b0;
      base = nacc;
      load(32'hE000_0000, 4);
      wait_acc(base + 4, 30);
      wait_idle(20);
      compared++;
      if (nacc !== base + 4 || err !== 1'b0) begin
         mismatched++;
         $display("FAIL rstmid_after: got words=%0d err=%b need 4/0", nacc - base, err);
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (got_d[base + i] !== 32'hE000_0000 + 32'(i) || got_l[base + i] !== (i == 3)) begin
            mismatched++;
            $display("FAIL rstmid_word[%0d]: got %h/%b need %h/%b", i, got_d[base + i], got_l[base + i],
                     32'hE000_0000 + 32'(i), i == 3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_full_rate();
      test_flush();
      test_backpressure();
      test_fail();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
